// File: rtl/ras_ckpt_if.sv
`default_nettype none
// ============================================================================
// Module      : ras_ckpt_if
// Description : Predictor-side bundle for the checkpointed return address
//               stack: push/pop/recover requests in, top-of-stack and
//               checkpoint out.
// Revision    : 1.0 - initial release
// ============================================================================
interface ras_ckpt_if #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CK_W  = PTR_W + (PTR_W + 1) + ADDR_W + CNT_W;

    logic              push_valid;
    logic [ADDR_W-1:0] push_addr;
    logic              pop_valid;
    logic              recover_valid;
    logic [CK_W-1:0]   recover_ckpt;
    logic [ADDR_W-1:0] top_addr;
    logic              top_valid;
    logic              full;
    logic [CK_W-1:0]   ckpt_o;

    // Front end issuing predictions and flushes
    modport master (
        output push_valid, push_addr, pop_valid, recover_valid, recover_ckpt,
        input  top_addr, top_valid, full, ckpt_o
    );

    // Stack itself
    modport slave (
        input  push_valid, push_addr, pop_valid, recover_valid, recover_ckpt,
        output top_addr, top_valid, full, ckpt_o
    );
endinterface
`default_nettype wire

// File: rtl/ras_ckpt.sv
`default_nettype none
// ============================================================================
// Module      : ras_ckpt
// Description : Circular return address stack with per-entry recursion
//               counters and single-cycle checkpoint restore. Checkpoint
//               layout is {ptr, occ, top addr, top cnt}, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_ckpt #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  wire logic  clk,
    input  wire logic  resetn,
    ras_ckpt_if.slave  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int CK_W    = PTR_W + OCC_W + ADDR_W + CNT_W;
    localparam int ADDR_LO = CNT_W;
    localparam int OCC_LO  = CNT_W + ADDR_W;
    localparam int PTR_LO  = CNT_W + ADDR_W + OCC_W;

    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [OCC_W-1:0] c_occ_full = OCC_W'(DEPTH);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [CNT_W-1:0]  r_cnt  [DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [OCC_W-1:0]  r_occ;

    logic [ADDR_W-1:0] w_top_addr;
    logic [CNT_W-1:0]  w_top_cnt;
    logic              w_empty;
    logic              w_hit;
    logic [PTR_W-1:0]  w_ck_ptr;
    logic [OCC_W-1:0]  w_ck_occ;
    logic [ADDR_W-1:0] w_ck_addr;
    logic [CNT_W-1:0]  w_ck_cnt;

    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [OCC_W-1:0]  w_occ_nxt;
    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [CNT_W-1:0]  w_wr_cnt;

    assign w_top_addr = r_addr[r_ptr];
    assign w_top_cnt  = r_cnt[r_ptr];
    assign w_empty    = (r_occ == '0);
    // Repeated call to the same target folds into the top entry until its
    // counter saturates, after which a fresh entry is opened instead.
    assign w_hit      = !w_empty && (bus.push_addr == w_top_addr) &&
                        (w_top_cnt != c_cnt_max);

    assign w_ck_ptr  = bus.recover_ckpt[PTR_LO  +: PTR_W];
    assign w_ck_occ  = bus.recover_ckpt[OCC_LO  +: OCC_W];
    assign w_ck_addr = bus.recover_ckpt[ADDR_LO +: ADDR_W];
    assign w_ck_cnt  = bus.recover_ckpt[0       +: CNT_W];

    assign bus.top_addr  = w_top_addr;
    assign bus.top_valid = !w_empty;
    assign bus.full      = (r_occ == c_occ_full);
    assign bus.ckpt_o    = {r_ptr, r_occ, w_top_addr, w_top_cnt};

    // Next pointer/occupancy and the single entry write of this cycle
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_occ_nxt = r_occ;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_ptr;
        w_wr_addr = w_top_addr;
        w_wr_cnt  = w_top_cnt;
        if (bus.recover_valid) begin
            w_ptr_nxt = w_ck_ptr;
            // A malformed checkpoint must not push occupancy past DEPTH
            w_occ_nxt = (w_ck_occ > c_occ_full) ? c_occ_full : w_ck_occ;
            w_wr_en   = 1'b1;
            w_wr_idx  = w_ck_ptr;
            w_wr_addr = w_ck_addr;
            w_wr_cnt  = w_ck_cnt;
        end else if (bus.push_valid && bus.pop_valid && !w_empty) begin
            // Return immediately followed by a call: replace the top entry
            w_wr_en   = 1'b1;
            w_wr_addr = bus.push_addr;
            w_wr_cnt  = c_cnt_one;
        end else if (bus.push_valid) begin
            w_wr_en = 1'b1;
            if (w_hit) begin
                w_wr_cnt = w_top_cnt + CNT_W'(1);
            end else begin
                w_ptr_nxt = r_ptr + PTR_W'(1);
                w_wr_idx  = r_ptr + PTR_W'(1);
                w_wr_addr = bus.push_addr;
                w_wr_cnt  = c_cnt_one;
                // When full the oldest entry is silently overwritten
                if (r_occ != c_occ_full) begin
                    w_occ_nxt = r_occ + OCC_W'(1);
                end
            end
        end else if (bus.pop_valid && !w_empty) begin
            w_wr_en = 1'b1;
            if (w_top_cnt > c_cnt_one) begin
                w_wr_cnt = w_top_cnt - CNT_W'(1);
            end else begin
                w_wr_cnt  = '0;
                w_ptr_nxt = r_ptr - PTR_W'(1);
                w_occ_nxt = r_occ - OCC_W'(1);
            end
        end
    end

    // Stack state register with asynchronous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_ptr <= w_ptr_nxt;
            r_occ <= w_occ_nxt;
            if (w_wr_en) begin
                r_addr[w_wr_idx] <= w_wr_addr;
                r_cnt[w_wr_idx]  <= w_wr_cnt;
            end
        end
    end
endmodule
`default_nettype wire
